// File: rtl/uart_cfg_bank.sv
// Command decoder and shadow/active register bank for the pattern-PWM/DAC channels.
// Shadow sets are committed while a channel is idle. Each command is answered with a UART frame.
module uart_cfg_bank #(
    parameter int _NUM_CHANNELS  = 4,
    parameter int _PAT_WIDTH     = 32,
    parameter int _PAYLOAD_BYTES = 10
) (
    input  logic                                 clk_50M,
    input  logic                                 rst_n,
    input  logic [7:0]                           func_reg,
    input  logic [8*_PAYLOAD_BYTES-1:0]          rev_data,
    input  logic                                 pack_done,
    input  logic [_NUM_CHANNELS-1:0]             ch_busy,
    output logic [_NUM_CHANNELS-1:0]             ch_en,
    output logic [8*_NUM_CHANNELS-1:0]           duty_bus,
    output logic [16*_NUM_CHANNELS-1:0]          dessert_bus,
    output logic [8*_NUM_CHANNELS-1:0]           pulse_num_bus,
    output logic [_PAT_WIDTH*_NUM_CHANNELS-1:0]  pat_bus,
    output logic [_NUM_CHANNELS-1:0]             commit_pulse,
    output logic [7:0]                           tx_data,
    output logic                                 tx_en,
    input  logic                                 tx_busy,
    output logic [7:0]                           err_cnt
);

    localparam int N         = _NUM_CHANNELS;
    localparam int PW        = _PAT_WIDTH;
    localparam int PB        = _PAT_WIDTH / 8;
    localparam int FRAME_MAX = 8 + PB;
    localparam int IW        = $clog2(FRAME_MAX + 1);

    localparam logic [7:0] F_SHADOW = 8'h01;
    localparam logic [7:0] F_CTRL   = 8'h02;
    localparam logic [7:0] F_COMMIT = 8'h03;
    localparam logic [7:0] F_READ   = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    state_t state_q, state_d;

    logic [7:0]              func_q;
    logic [8*_PAYLOAD_BYTES-1:0] pay_q;

    logic [7:0]    sh_duty_q [N];
    logic [15:0]   sh_dess_q [N];
    logic [7:0]    sh_pnum_q [N];
    logic [PW-1:0] sh_pat_q  [N];

    logic [7:0]    act_ctrl_q [N];
    logic [7:0]    act_duty_q [N];
    logic [15:0]   act_dess_q [N];
    logic [7:0]    act_pnum_q [N];
    logic [PW-1:0] act_pat_q  [N];

    logic [N-1:0]  pending_q, pending_d, fire, commit_q, set_mask;

    logic [7:0]    frame_q [FRAME_MAX];
    logic [7:0]    frame_d [FRAME_MAX];
    logic [IW-1:0] len_q, len_d, idx_q;

    logic          tx_en_q;
    logic [7:0]    tx_data_q;
    logic [7:0]    err_q;

    logic          accept, drop, exec, tx_fire;
    logic          nak, ch_ok, mask_ok;
    logic [7:0]    nak_code;
    logic          do_shadow, do_ctrl;

    logic [7:0]    cmd_ch, cmd_ctrl, cmd_duty, cmd_pnum;
    logic [15:0]   cmd_dess;
    logic [PW-1:0] cmd_pat;

    logic [7:0]    rb_ctrl, rb_duty, rb_pnum;
    logic [15:0]   rb_dess;
    logic [PW-1:0] rb_pat;

    // FSM: state register / next state / outputs
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (pack_done) state_d = S_EXEC;
            S_EXEC:    state_d = S_SEND;
            S_SEND:    if (!tx_busy) state_d = S_WAIT_HI;
            S_WAIT_HI: if (tx_busy) state_d = S_WAIT_LO;
            S_WAIT_LO: if (!tx_busy) state_d = (idx_q < len_q) ? S_SEND : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept  = (state_q == S_IDLE) && pack_done;
        drop    = (state_q != S_IDLE) && pack_done;
        exec    = (state_q == S_EXEC);
        tx_fire = (state_q == S_SEND) && !tx_busy;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            func_q <= '0;
            pay_q  <= '0;
        end else if (accept) begin
            func_q <= func_reg;
            pay_q  <= rev_data;
        end
    end

    // Payload field extraction: byte k sits at [8k-1:8k-8], multi-byte fields MSB first
    always_comb begin
        cmd_ch   = pay_q[7:0];
        cmd_ctrl = pay_q[15:8];
        cmd_duty = pay_q[23:16];
        cmd_dess = {pay_q[31:24], pay_q[39:32]};
        cmd_pnum = pay_q[47:40];
        cmd_pat  = '0;
        for (int b = 0; b < PB; b++) begin
            cmd_pat[PW-1-8*b -: 8] = pay_q[8*b+55 -: 8];
        end
    end

    always_comb begin
        ch_ok    = (int'(cmd_ch) < N);
        mask_ok  = ((cmd_ch >> N) == 8'd0);
        nak      = 1'b0;
        nak_code = 8'h00;
        case (func_q)
            F_SHADOW, F_CTRL, F_READ: begin
                if (!ch_ok) begin
                    nak      = 1'b1;
                    nak_code = 8'h01;
                end
            end
            F_COMMIT: begin
                if (!mask_ok) begin
                    nak      = 1'b1;
                    nak_code = 8'h01;
                end
            end
            default: begin
                nak      = 1'b1;
                nak_code = 8'h02;
            end
        endcase
        do_shadow = exec && (func_q == F_SHADOW) && !nak;
        do_ctrl   = exec && (func_q == F_CTRL) && !nak;
        set_mask  = (exec && (func_q == F_COMMIT) && !nak) ? cmd_ch[N-1:0] : '0;
    end

    // Commit runs every cycle regardless of FSM state; a new COMMIT re-arms pending.
    always_comb begin
        fire      = pending_q & ~ch_busy;
        pending_d = (pending_q & ~fire) | set_mask;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                sh_duty_q[i] <= '0;
                sh_dess_q[i] <= '0;
                sh_pnum_q[i] <= '0;
                sh_pat_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (do_shadow && (cmd_ch == 8'(i))) begin
                    sh_duty_q[i] <= cmd_duty;
                    sh_dess_q[i] <= cmd_dess;
                    sh_pnum_q[i] <= cmd_pnum;
                    sh_pat_q[i]  <= cmd_pat;
                end
            end
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            commit_q  <= '0;
            for (int i = 0; i < N; i++) begin
                act_ctrl_q[i] <= '0;
                act_duty_q[i] <= '0;
                act_dess_q[i] <= '0;
                act_pnum_q[i] <= '0;
                act_pat_q[i]  <= '0;
            end
        end else begin
            pending_q <= pending_d;
            commit_q  <= fire;
            for (int i = 0; i < N; i++) begin
                if (do_ctrl && (cmd_ch == 8'(i))) act_ctrl_q[i] <= cmd_ctrl;
                if (fire[i]) begin
                    act_duty_q[i] <= sh_duty_q[i];
                    act_dess_q[i] <= sh_dess_q[i];
                    act_pnum_q[i] <= sh_pnum_q[i];
                    act_pat_q[i]  <= sh_pat_q[i];
                end
            end
        end
    end

    always_comb begin
        rb_ctrl = '0;
        rb_duty = '0;
        rb_dess = '0;
        rb_pnum = '0;
        rb_pat  = '0;
        for (int i = 0; i < N; i++) begin
            if (cmd_ch == 8'(i)) begin
                rb_ctrl = act_ctrl_q[i];
                rb_duty = act_duty_q[i];
                rb_dess = act_dess_q[i];
                rb_pnum = act_pnum_q[i];
                rb_pat  = act_pat_q[i];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < FRAME_MAX; k++) frame_d[k] = '0;
        frame_d[0] = 8'hA5;
        frame_d[1] = func_q | {nak, 7'd0};
        frame_d[2] = nak ? nak_code : cmd_ch;
        frame_d[3] = rb_ctrl;
        frame_d[4] = rb_duty;
        frame_d[5] = rb_dess[15:8];
        frame_d[6] = rb_dess[7:0];
        frame_d[7] = rb_pnum;
        for (int b = 0; b < PB; b++) begin
            frame_d[8+b] = rb_pat[PW-1-8*b -: 8];
        end
        len_d = ((func_q == F_READ) && !nak) ? IW'(FRAME_MAX) : IW'(3);
    end

    // Response frame is frozen in EXEC so later register traffic cannot alter it
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FRAME_MAX; k++) frame_q[k] <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            err_q     <= '0;
        end else begin
            if (exec) begin
                frame_q <= frame_d;
                len_q   <= len_d;
                idx_q   <= '0;
            end else if (tx_fire) begin
                idx_q   <= idx_q + IW'(1);
            end
            tx_en_q <= tx_fire;
            if (tx_fire) tx_data_q <= frame_q[idx_q];
            err_q <= sat_add(err_q, {1'b0, drop} + {1'b0, exec && nak});
        end
    end

    always_comb begin
        ch_en         = '0;
        duty_bus      = '0;
        dessert_bus   = '0;
        pulse_num_bus = '0;
        pat_bus       = '0;
        for (int i = 0; i < N; i++) begin
            ch_en[i]                 = act_ctrl_q[i][0];
            duty_bus[8*i +: 8]       = act_duty_q[i];
            dessert_bus[16*i +: 16]  = act_dess_q[i];
            pulse_num_bus[8*i +: 8]  = act_pnum_q[i];
            pat_bus[PW*i +: PW]      = act_pat_q[i];
        end
    end

    assign commit_pulse = commit_q;
    assign tx_en        = tx_en_q;
    assign tx_data      = tx_data_q;
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_uart_cfg_bank.sv
// Scoreboard bench for uart_cfg_bank: expected TX bytes are queued at stimulus time
// and a monitor pops them on every tx_en; register state is checked against constants.
module tb_uart_cfg_bank;

    localparam int N  = 4;
    localparam int PW = 32;
    localparam int PB = 10;

    logic              clk_50M = 1'b0;
    logic              rst_n;
    logic [7:0]        func_reg;
    logic [8*PB-1:0]   rev_data;
    logic              pack_done;
    logic [N-1:0]      ch_busy;
    logic [N-1:0]      ch_en;
    logic [8*N-1:0]    duty_bus;
    logic [16*N-1:0]   dessert_bus;
    logic [8*N-1:0]    pulse_num_bus;
    logic [PW*N-1:0]   pat_bus;
    logic [N-1:0]      commit_pulse;
    logic [7:0]        tx_data;
    logic              tx_en;
    logic              tx_busy;
    logic [7:0]        err_cnt;

    int checks = 0;
    int errors = 0;
    int cp_cnt = 0;
    int tx_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    uart_cfg_bank #(._NUM_CHANNELS(N), ._PAT_WIDTH(PW), ._PAYLOAD_BYTES(PB)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .func_reg(func_reg), .rev_data(rev_data),
        .pack_done(pack_done), .ch_busy(ch_busy), .ch_en(ch_en), .duty_bus(duty_bus),
        .dessert_bus(dessert_bus), .pulse_num_bus(pulse_num_bus), .pat_bus(pat_bus),
        .commit_pulse(commit_pulse), .tx_data(tx_data), .tx_en(tx_en),
        .tx_busy(tx_busy), .err_cnt(err_cnt)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic ck(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [8*PB-1:0] mk(input logic [7:0] ch, input logic [7:0] ctrl,
                                           input logic [7:0] duty, input logic [15:0] dess,
                                           input logic [7:0] pnum, input logic [31:0] pat);
        return {pat[7:0], pat[15:8], pat[23:16], pat[31:24], pnum, dess[7:0], dess[15:8],
                duty, ctrl, ch};
    endfunction

    task automatic push3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
    endtask

    task automatic send(input logic [7:0] f, input logic [8*PB-1:0] p);
        @(negedge clk_50M);
        func_reg  = f;
        rev_data  = p;
        pack_done = 1'b1;
        @(negedge clk_50M);
        pack_done = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk_50M);
            n++;
        end
        ck("frame_drained", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        repeat (10) @(negedge clk_50M);
    endtask

    // UART transmitter model: busy shortly after each send strobe
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk_50M);
            if (tx_en === 1'b1) begin
                tx_busy = 1'b1;
                repeat (5) @(negedge clk_50M);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_50M);
            if (commit_pulse !== '0) cp_cnt++;
            if (tx_en === 1'b1) begin
                tx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    ck("tx_byte", 128'(tx_data), 128'(mon_e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cp0, tx0, n;
        rst_n = 1'b0; pack_done = 1'b0; func_reg = '0; rev_data = '0; ch_busy = '0;
        repeat (3) @(negedge clk_50M);
        ck("rst_duty", 128'(duty_bus), 128'd0);
        ck("rst_pat", 128'(pat_bus), 128'd0);
        ck("rst_ch_en", 128'(ch_en), 128'd0);
        ck("rst_tx", 128'({tx_en, tx_data, err_cnt, commit_pulse}), 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50M);

        // shadow write leaves active untouched
        push3(8'hA5, 8'h01, 8'h01);
        send(8'h01, mk(8'd1, 8'h00, 8'h10, 16'h0203, 8'h05, 32'hDEADBEEF));
        repeat (3) @(negedge clk_50M);
        ck("shadow_no_active_duty", 128'(duty_bus), 128'd0);
        ck("shadow_no_active_pat", 128'(pat_bus), 128'd0);
        drain();

        // commit with ch_busy low: visible at T+3 with a single-cycle pulse
        push3(8'hA5, 8'h03, 8'h02);
        send(8'h03, mk(8'h02, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0));
        @(negedge clk_50M);
        ck("commit_pulse_T2", 128'(commit_pulse), 128'd0);
        @(negedge clk_50M);
        ck("commit_pulse_T3", 128'(commit_pulse), 128'h2);
        ck("commit_duty", 128'(duty_bus), 128'h0000_1000);
        ck("commit_dess", 128'(dessert_bus), 128'h0000_0000_0203_0000);
        ck("commit_pnum", 128'(pulse_num_bus), 128'h0000_0500);
        ck("commit_pat", 128'(pat_bus), 128'h00000000_00000000_DEADBEEF_00000000);
        @(negedge clk_50M);
        ck("commit_pulse_T4", 128'(commit_pulse), 128'd0);
        drain();

        // readback of channel 1
        push3(8'hA5, 8'h04, 8'h01);
        push3(8'h00, 8'h10, 8'h02);
        push3(8'h03, 8'h05, 8'hDE);
        push3(8'hAD, 8'hBE, 8'hEF);
        send(8'h04, mk(8'd1, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0));
        drain();

        // busy-gated commit
        push3(8'hA5, 8'h01, 8'h01);
        send(8'h01, mk(8'd1, 8'h00, 8'h22, 16'h0405, 8'h07, 32'h12345678));
        drain();
        ch_busy = 4'b0010;
        cp0 = cp_cnt;
        push3(8'hA5, 8'h03, 8'h02);
        send(8'h03, mk(8'h02, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0));
        repeat (50) @(negedge clk_50M);
        ck("busy_hold_pulses", 128'(cp_cnt - cp0), 128'd0);
        ck("busy_hold_duty", 128'(duty_bus), 128'h0000_1000);
        ch_busy = 4'b0000;
        @(negedge clk_50M);
        ck("busy_release_pulse", 128'(commit_pulse), 128'h2);
        ck("busy_release_duty", 128'(duty_bus), 128'h0000_2200);
        ck("busy_release_pat", 128'(pat_bus), 128'h00000000_00000000_12345678_00000000);
        @(negedge clk_50M);
        ck("busy_release_pulse_end", 128'(commit_pulse), 128'd0);
        drain();

        // immediate ctrl
        push3(8'hA5, 8'h02, 8'h03);
        send(8'h02, mk(8'd3, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0));
        ck("ctrl_before_T2", 128'(ch_en), 128'd0);
        @(negedge clk_50M);
        ck("ctrl_T2", 128'(ch_en), 128'h8);
        drain();

        // NAKs
        cp0 = cp_cnt;
        push3(8'hA5, 8'h81, 8'h01);
        send(8'h01, mk(8'd4, 8'h00, 8'h77, 16'h1111, 8'h09, 32'hCAFEF00D));
        drain();
        push3(8'hA5, 8'h89, 8'h02);
        send(8'h09, mk(8'd0, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0));
        drain();
        push3(8'hA5, 8'h83, 8'h01);
        send(8'h03, mk(8'h11, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0));
        drain();
        ck("nak_err_cnt", 128'(err_cnt), 128'd3);
        ck("nak_no_commit", 128'(cp_cnt - cp0), 128'd0);
        ck("nak_duty", 128'(duty_bus), 128'h0000_2200);
        ck("nak_ch_en", 128'(ch_en), 128'h8);

        // overrun: second packet while the response is in flight
        push3(8'hA5, 8'h02, 8'h00);
        send(8'h02, mk(8'd0, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0));
        repeat (4) @(negedge clk_50M);
        send(8'h02, mk(8'd2, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0));
        drain();
        ck("overrun_err_cnt", 128'(err_cnt), 128'd4);
        ck("overrun_ch_en", 128'(ch_en), 128'h9);

        // park a pending commit on busy ch0, then reset in the middle of a readback
        ch_busy = 4'b0001;
        push3(8'hA5, 8'h03, 8'h01);
        send(8'h03, mk(8'h01, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0));
        drain();
        push3(8'hA5, 8'h04, 8'h01);
        push3(8'h00, 8'h22, 8'h04);
        push3(8'h05, 8'h07, 8'h12);
        push3(8'h34, 8'h56, 8'h78);
        send(8'h04, mk(8'd1, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0));
        n = 0;
        while (exp_q.size() > 9 && n < 1000) begin
            @(negedge clk_50M);
            n++;
        end
        ck("midframe_reached", 128'(exp_q.size()), 128'd9);
        rst_n = 1'b0;
        exp_q.delete();
        tx0 = tx_cnt;
        cp0 = cp_cnt;
        @(negedge clk_50M);
        ck("mid_rst_buses", 128'({ch_en, duty_bus, pulse_num_bus, commit_pulse}), 128'd0);
        ck("mid_rst_pat", 128'(pat_bus), 128'd0);
        ck("mid_rst_tx", 128'({tx_en, tx_data, err_cnt}), 128'd0);
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        ch_busy = 4'b0000;
        repeat (40) @(negedge clk_50M);
        ck("post_rst_tx_silent", 128'(tx_cnt - tx0), 128'd0);
        ck("post_rst_pending_cleared", 128'(cp_cnt - cp0), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
